// File: rtl/titan_wb_pkg.sv
// Shared definitions for the Titan Wishbone initiator: size encodings,
// byte-lane select patterns, the initiator state enum and the alignment rule.
package titan_wb_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [3:0] SEL_BYTE = 4'h1;
    localparam logic [3:0] SEL_HALF = 4'h3;
    localparam logic [3:0] SEL_WORD = 4'hf;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS   = 2'd1,
        FAULT = 2'd2
    } wb_state_e;

    // True when the access can be issued on the bus; size 3 is never legal.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~addr_lo[0];
            SZ_WORD: ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Bus-cycle watchdog: cleared when a cycle starts, counts every cycle the
// bus is busy, saturates at TIMEOUT. expire flags the edge on which the
// count reaches TIMEOUT. TIMEOUT = 0 disables it.
module wb_timeout_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CW-1:0] cnt;

    // Count busy cycles; hold at the limit instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != CNT_MAX)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expire = (TIMEOUT != 0) && en && (cnt == CNT_LAST);

endmodule

// File: rtl/wb_master_port.sv
// Wishbone classic initiator for the Titan memory stage. Takes one load or
// store at a time, issues the bus cycle, and returns a one-cycle response.
//
// Handshakes: a request transfers on a rising edge where req_valid and
// req_ready are both 1; req_valid may be held, and request fields are only
// looked at on that edge. rsp_valid is a one-cycle pulse with no ready: the
// core must take rsp_rdata/rsp_err in that cycle. On the bus side cyc_o/stb_o
// stay high with stable addr/dat/sel/we until ack_i, err_i or the watchdog
// ends the cycle; ack_i/err_i are ignored at any other time.
module wb_master_port
    import titan_wb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] addr_o,
    output logic [31:0] dat_o,
    output logic [3:0]  sel_o,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i,
    input  logic        err_i,
    output logic [1:0]  dbg_state
);

    wb_state_e   state, state_n;
    logic        cyc_n, stb_n, we_n;
    logic [31:0] addr_n, dat_n;
    logic [3:0]  sel_n;
    logic [1:0]  size_q, size_n;
    logic        uns_q, uns_n;
    logic        rsp_valid_n, rsp_err_n;
    logic [31:0] rsp_rdata_n;
    logic [31:0] load_data;
    logic        cnt_clr, cnt_en, tmo_expire;

    assign req_ready = rst && (state == IDLE);
    assign dbg_state = state;

    wb_timeout_counter #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .expire(tmo_expire)
    );

    // Right-justified load value, extended per the size/flag latched at acceptance.
    always_comb begin
        load_data = dat_i;
        case (size_q)
            SZ_BYTE: load_data = uns_q ? {24'h0, dat_i[7:0]}   : {{24{dat_i[7]}}, dat_i[7:0]};
            SZ_HALF: load_data = uns_q ? {16'h0, dat_i[15:0]}  : {{16{dat_i[15]}}, dat_i[15:0]};
            default: load_data = dat_i;
        endcase
    end

    // Next state plus next values of every registered bus and response output.
    always_comb begin
        state_n     = state;
        cyc_n       = cyc_o;
        stb_n       = stb_o;
        we_n        = we_o;
        addr_n      = addr_o;
        dat_n       = dat_o;
        sel_n       = sel_o;
        size_n      = size_q;
        uns_n       = uns_q;
        rsp_valid_n = 1'b0;
        rsp_err_n   = 1'b0;
        rsp_rdata_n = '0;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    size_n = req_size;
                    uns_n  = req_unsigned;
                    if (is_aligned(req_size, req_addr[1:0])) begin
                        state_n = BUS;
                        cyc_n   = 1'b1;
                        stb_n   = 1'b1;
                        we_n    = req_we;
                        addr_n  = req_addr;
                        cnt_clr = 1'b1;
                        case (req_size)
                            SZ_BYTE: begin
                                sel_n = SEL_BYTE;
                                dat_n = {4{req_wdata[7:0]}};
                            end
                            SZ_HALF: begin
                                sel_n = SEL_HALF;
                                dat_n = {2{req_wdata[15:0]}};
                            end
                            default: begin
                                sel_n = SEL_WORD;
                                dat_n = req_wdata;
                            end
                        endcase
                    end else begin
                        state_n = FAULT;
                    end
                end
            end
            BUS: begin
                cnt_en = 1'b1;
                if (err_i || ack_i || tmo_expire) begin
                    state_n     = IDLE;
                    cyc_n       = 1'b0;
                    stb_n       = 1'b0;
                    rsp_valid_n = 1'b1;
                    // err beats ack; ack on the expiry edge still counts as success
                    if (err_i || !ack_i) begin
                        rsp_err_n = 1'b1;
                    end else if (!we_o) begin
                        rsp_rdata_n = load_data;
                    end
                end
            end
            FAULT: begin
                state_n     = IDLE;
                rsp_valid_n = 1'b1;
                rsp_err_n   = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers; reset clears everything and abandons any cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cyc_o     <= 1'b0;
            stb_o     <= 1'b0;
            we_o      <= 1'b0;
            addr_o    <= '0;
            dat_o     <= '0;
            sel_o     <= '0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_n;
            cyc_o     <= cyc_n;
            stb_o     <= stb_n;
            we_o      <= we_n;
            addr_o    <= addr_n;
            dat_o     <= dat_n;
            sel_o     <= sel_n;
            size_q    <= size_n;
            uns_q     <= uns_n;
            rsp_valid <= rsp_valid_n;
            rsp_err   <= rsp_err_n;
            rsp_rdata <= rsp_rdata_n;
        end
    end

endmodule

// File: doc/wb_master_port.md
# wb_master_port

Wishbone classic initiator that turns single load/store requests from the Titan core's memory stage into bus cycles toward `bram` and other Wishbone responders. It checks alignment, drives `cyc/stb/we/sel/addr/dat`, waits for `ack` or `err` with a timeout, and returns load data to the core as a one-cycle response pulse. Load data is sign- or zero-extended. The block handles one outstanding transaction at a time.

## Interface
- `TIMEOUT`, default 255: number of cycles to wait for `ack_i`/`err_i` before aborting. 0 disables the timeout.
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `req_valid` input 1: core request present.
- `req_ready` output 1: block can accept a request.
- `req_we` input 1: 1 for store, 0 for load.
- `req_size` input 2: 0 = byte, 1 = half, 2 = word, 3 = illegal.
- `req_unsigned` input 1: zero-extend loads; otherwise sign-extend.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data, right-justified.
- `rsp_valid` output 1: one-cycle response pulse.
- `rsp_rdata` output 32: extended load data; 0 for stores and errors.
- `rsp_err` output 1: bus error, timeout, misalignment or illegal size.
- `addr_o` output 32, `dat_o` output 32, `sel_o` output 4, `cyc_o` output 1, `stb_o` output 1, `we_o` output 1: Wishbone master outputs.
- `dat_i` input 32, `ack_i` input 1, `err_i` input 1: Wishbone responder inputs.

## Operation
**States**
- IDLE: `req_ready` = 1.
- BUS: cycle in flight.
- FAULT: one cycle, used to report a misaligned or illegal request.

**Request acceptance**
- A request is accepted when `req_valid & req_ready` at a rising edge.
- A half request with `addr[0]`=1, a word request with `addr[1:0]`≠0, or `req_size`=3 goes to FAULT. No bus cycle is issued.
- Any other accepted request goes to BUS.

**Bus drive on entry to BUS (all registered)**
- `cyc_o` = `stb_o` = 1, `we_o` = `req_we`, `addr_o` = `req_addr`.
- `sel_o` = 4'h1 for byte, 4'h3 for half, 4'hf for word.
- `dat_o` = `{4{wdata[7:0]}}` for byte, `{2{wdata[15:0]}}` for half, `wdata` for word.
- All these outputs are held stable until the cycle terminates.

**Termination in BUS**
- A cycle terminates on the first edge where `ack_i` or `err_i` is 1, or where the timeout counter reaches `TIMEOUT`.
- On termination: `cyc_o`/`stb_o` drop, the state returns to IDLE, `rsp_valid` pulses in the following cycle, and `dat_i` is captured at that same edge.
- `err_i` has priority over `ack_i` when both are 1; `rsp_err` = 1 in that case.
- Timeout gives `rsp_err` = 1.

**Load extraction**
- byte: `dat_i[7:0]`.
- half: `dat_i[15:0]`.
- word: `dat_i`.
- Extension to 32 bits follows `req_unsigned`. The size and unsigned flag are latched at acceptance.

**Other rules**
- FAULT produces `rsp_valid` = 1 with `rsp_err` = 1, then returns to IDLE.
- `ack_i`/`err_i` are ignored outside BUS.
- Timeout counter: `$clog2(TIMEOUT+1)` bits, cleared on entry to BUS, increments every BUS cycle, never wraps.

## Timing
**Reset values**
- All outputs reset to 0 and the state resets to IDLE.
- `req_ready` is forced to 0 while `rst` is low.

**Reset mid-cycle**
- `cyc_o`/`stb_o` drop asynchronously.
- The transaction is discarded and no response is ever issued for it.

**Latency**
- Let E0 be the acceptance edge. `cyc_o` is high after E0.
- With a responder whose ack is registered one cycle after `stb` (as `bram`), `ack_i` is sampled at E2.
- `rsp_valid` is high for exactly the cycle after E2, and `cyc_o` is low in that cycle.
- For a zero-wait responder this is 2 cycles from acceptance to response.
- A misaligned request responds after E1.

**Back-to-back requests**
- `req_ready` is 1 during the `rsp_valid` cycle, so a new request can be accepted at E3 and `cyc_o` rises again after E3.
- `cyc_o` is low for at least one cycle between transactions.

**Response handshake**
- The core must consume `rsp_valid` in its pulse cycle; there is no back-pressure.

**Timeout boundary**
- With `TIMEOUT`=N and no response, the abort happens at the Nth BUS edge.
- An `ack_i` arriving on that same edge wins and is treated as success.

## Structure
- Shared package `titan_wb_pkg` holds:
  - size encodings `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`;
  - `SEL_BYTE`=4'h1, `SEL_HALF`=4'h3, `SEL_WORD`=4'hf;
  - the state enum IDLE/BUS/FAULT;
  - a function giving the alignment check for a size/address pair.
- One sub-module, `wb_timeout_counter`, holds the clear/enable/expire counter parameterised by `TIMEOUT`.
- Load extraction and write replication stay inline.

## Test plan
- **Word store then load.** Store size=2, addr=0x10, wdata=0xDEADBEEF, against `bram` → `sel_o`=4'hf, `we_o`=1, `rsp_valid` 2 cycles after acceptance with `rsp_err`=0. Then load the same address → `rsp_rdata`=0xDEADBEEF.
- **Byte load, sign and zero extension.** Byte load at addr=0x13 where memory holds 0x97 → signed `rsp_rdata`=0xFFFFFF97; with `req_unsigned`=1, `rsp_rdata`=0x00000097; `sel_o`=4'h1 in both.
- **Misaligned requests.** Half load at addr=0x5 and word store at addr=0x6 → `cyc_o` never rises, `rsp_err`=1 one cycle after acceptance, `rsp_rdata`=0.
- **Error priority and timeout.** A responder asserting `ack_i` and `err_i` together → `rsp_err`=1. With `TIMEOUT`=4 and a responder that stays silent → `cyc_o` drops after 4 BUS cycles and `rsp_err`=1.
- **Back-to-back loads.** Two loads with `req_valid` held → the second is accepted in the first's `rsp_valid` cycle, with exactly one idle cycle of `cyc_o` between them.
- **Reset mid-cycle.** Assert `rst`=0 while in BUS with a stalled responder → `cyc_o`/`stb_o` = 0 immediately, and no `rsp_valid` appears after reset is released.
